// File: rtl/weight_check_pkg.sv
// Shared types, defaults and width helper for the weight_check block.
// WEIGHT_CHECK_LOCKOUT_EN adds the S_LOCK state after repeated mismatches.
package weight_check_pkg;

   localparam int M_DEF      = 256;
   localparam int CHUNK_DEF  = 8;
   localparam int THRESH_DEF = 40;

`ifdef WEIGHT_CHECK_LOCKOUT_EN
   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC,
      S_POST,
      S_LOCK
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC,
      S_POST
   } state_t;
`endif

   function automatic int weight_width(input int m);
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/weight_check_popcnt.sv
// Combinational population count of one CHUNK-bit slice.
// Reduces the low slice of the difference register each cycle.
module chunk_popcnt
   import weight_check_pkg::*;
#(
   parameter int CHUNK = CHUNK_DEF
) (
   input  logic [CHUNK-1:0]             bits,
   output logic [$clog2(CHUNK+1)-1:0]   count
);

   localparam int PW = $clog2(CHUNK + 1);

   // Sum the set bits of the slice
   always_comb begin
      count = '0;
      for (int i = 0; i < CHUNK; i++) begin
         count = count + PW'(bits[i]);
      end
   end

endmodule

// File: rtl/weight_check.sv
// Hamming-distance match check of a product vector against a reference.
// WEIGHT_CHECK_LOCKOUT_EN: lock after three consecutive mismatches.
module weight_check
   import weight_check_pkg::*;
#(
   parameter int M      = M_DEF,
   parameter int CHUNK  = CHUNK_DEF,
   parameter int THRESH = THRESH_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [M-1:0]                prod_in,
   input  logic                        prod_valid,
   output logic                        prod_ready,
   input  logic [M-1:0]                ref_in,
   output logic [weight_width(M)-1:0]  weight,
   output logic                        match,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic                        busy
);

   localparam int WW = weight_width(M);
   localparam int N  = M / CHUNK;
   localparam int CW = $clog2(N + 1);
   localparam int PW = $clog2(CHUNK + 1);

   state_t          state;
   logic [M-1:0]    diff;
   logic [WW-1:0]   acc;
   logic [CW-1:0]   cnt;
   logic [PW-1:0]   pop;
   logic [WW-1:0]   sum;
   logic            last;
`ifdef WEIGHT_CHECK_LOCKOUT_EN
   logic [1:0]      fails;
`endif

   chunk_popcnt #(
      .CHUNK (CHUNK)
   ) u_pop (
      .bits  (diff[CHUNK-1:0]),
      .count (pop)
   );

   assign sum  = acc + WW'(pop);
   assign last = (cnt == CW'(N - 1));

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         prod_ready <= 1'b0;
         res_valid  <= 1'b0;
         busy       <= 1'b0;
         weight     <= '0;
         match      <= 1'b0;
         diff       <= '0;
         acc        <= '0;
         cnt        <= '0;
`ifdef WEIGHT_CHECK_LOCKOUT_EN
         fails      <= '0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (prod_valid && prod_ready) begin
                  diff       <= prod_in ^ ref_in;
                  acc        <= '0;
                  cnt        <= '0;
                  state      <= S_ACC;
                  prod_ready <= 1'b0;
                  busy       <= 1'b1;
               end else begin
                  prod_ready <= 1'b1;
               end
            end
            S_ACC: begin
               acc  <= sum;
               diff <= diff >> CHUNK;
               cnt  <= cnt + 1'b1;
               if (last) begin
                  state     <= S_POST;
                  busy      <= 1'b0;
                  res_valid <= 1'b1;
                  weight    <= sum;
                  match     <= (int'(sum) <= THRESH);
               end
            end
            S_POST: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
`ifdef WEIGHT_CHECK_LOCKOUT_EN
                  if (match) begin
                     fails      <= '0;
                     state      <= S_IDLE;
                     prod_ready <= 1'b1;
                  end else if (fails == 2'd2) begin
                     fails <= fails + 1'b1;
                     state <= S_LOCK;
                  end else begin
                     fails      <= fails + 1'b1;
                     state      <= S_IDLE;
                     prod_ready <= 1'b1;
                  end
`else
                  state      <= S_IDLE;
                  prod_ready <= 1'b1;
`endif
               end
            end
            default: begin
               prod_ready <= 1'b0;
               res_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule
